mips_instr_encoder: RTL and testbench

//  Encoder counterpart of the control/ALU decode path: turns symbolic instruction requests
//  (operation + register/immediate fields) into 32-bit MIPS words whose opcode/funct match

---
 rtl/mips_instr_encoder.sv | 115 +++++++++++
 tb/tb_mips_instr_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Turns symbolic MIPS requests into 32-bit instruction words and streams them, with byte
// addresses, through a 2-entry buffer to an instruction-memory writer.
module mips_instr_encoder #(
  parameter int unsigned             ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
  parameter int unsigned             MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       word_count,
  output logic              done,
  output logic              err_illegal
);

  typedef enum logic {RUN, HALT} state_e;

  state_e             state_q;
  logic [1:0][31:0]   fifo_q;
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        wcnt_q, pushed_q;
  logic               err_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept, push, pop, last_pop;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_op)
      4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      4'd2:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      4'd3:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      4'd4:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      4'd5:    enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
      4'd6:    enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
      4'd7:    enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
      4'd8:    enc_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
      4'd9:    enc_word = {6'h02, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // Budget is counted on pushes so the block never encodes more than MAX_WORDS words.
  assign in_ready   = (state_q == RUN) && (cnt_q != 2'd2) &&
                      (pushed_q < 16'(MAX_WORDS)) && !restart;
  assign accept     = in_valid && in_ready;
  assign push       = accept && enc_legal;
  assign out_valid  = (state_q == RUN) && (cnt_q != 2'd0);
  assign pop        = out_valid && out_ready && !restart;
  assign last_pop   = pop && ((wcnt_q + 16'd1) == 16'(MAX_WORDS));

  assign out_instr   = out_valid ? fifo_q[rd_ptr_q] : 32'd0;
  assign out_addr    = addr_q;
  assign word_count  = wcnt_q;
  assign done        = (state_q == HALT);
  assign err_illegal = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      fifo_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      addr_q   <= BASE_ADDR;
      wcnt_q   <= 16'd0;
      pushed_q <= 16'd0;
      err_q    <= 1'b0;
    end else if (restart) begin
      state_q  <= RUN;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      addr_q   <= BASE_ADDR;
      wcnt_q   <= 16'd0;
      pushed_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= enc_word;
        wr_ptr_q         <= ~wr_ptr_q;
        pushed_q         <= pushed_q + 16'd1;
      end
      if (accept && !enc_legal) err_q <= 1'b1;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        addr_q   <= addr_q + ADDR_W'(4);
        wcnt_q   <= wcnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (last_pop) state_q <= HALT;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed cases plus randomized episodes against
// an arithmetic reference encoder; a separate monitor checks every presented word.
module tb_mips_instr_encoder;
  localparam int          AW   = 8;
  localparam logic [7:0]  BASE = 8'hF0;
  localparam int          MAXW = 6;

  logic        clk = 1'b0, reset = 1'b1, restart = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [25:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [AW-1:0] out_addr;
  logic [15:0] word_count;
  logic        done, err_illegal;

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .word_count(word_count), .done(done), .err_illegal(err_illegal));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] instr; logic [7:0] addr; } exp_t;
  exp_t sb_q[$];
  int   checks = 0, failures = 0;
  int   exp_pushed = 0, exp_pops = 0, n_acc = 0;
  bit   exp_err = 1'b0, started = 1'b0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: field values placed by weight; -1 marks an illegal op.
  function automatic longint ref_encode(int op, int rs, int rt, int rd, int imm);
    int funct[5];
    int iop[4];
    funct = '{32, 34, 36, 37, 42};
    iop   = '{35, 43, 4, 8};
    if (op < 5)  return longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + funct[op];
    if (op < 9)  return longint'(iop[op-5]) * 67108864 + longint'(rs) * 2097152 +
                        longint'(rt) * 65536 + (imm % 65536);
    if (op == 9) return 2 * 67108864 + (imm % 67108864);
    return -1;
  endfunction

  task automatic expect_word(logic [31:0] w);
    exp_t e;
    e.instr = w;
    e.addr  = 8'(int'(BASE) + 4 * exp_pushed);
    sb_q.push_back(e);
    exp_pushed++;
  endtask

  task automatic clear_model();
    sb_q.delete();
    exp_pushed = 0; exp_pops = 0; exp_err = 1'b0;
  endtask

  // One cycle of stimulus; lit is used as the expected word when use_model is 0.
  task automatic step(bit v, int op, int rs, int rt, int rd, int imm, bit ordy,
                      bit use_model, logic [31:0] lit, output bit acc);
    longint w;
    @(posedge clk); #1;
    in_valid = v; in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 26'(imm); out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      n_acc++;
      w = ref_encode(op, rs, rt, rd, imm);
      if (w < 0) exp_err = 1'b1;
      else expect_word(use_model ? w[31:0] : lit);
    end
  endtask

  task automatic send(int op, int rs, int rt, int rd, int imm, bit ordy, bit use_model,
                      logic [31:0] lit);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 20) begin
      step(1'b1, op, rs, rt, rd, imm, ordy, use_model, lit, acc);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(bit ordy, int n);
    bit acc;
    repeat (n) step(1'b0, 0, 0, 0, 0, 0, ordy, 1'b1, 32'd0, acc);
  endtask

  task automatic do_restart();
    @(posedge clk); #1;
    restart = 1'b1; in_valid = 1'b1; in_op = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_during_restart", in_ready, 0);
    clear_model();
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("restart_done", done, 0);
    check("restart_addr", out_addr, BASE);
    check("restart_err", err_illegal, 0);
    check("restart_valid", out_valid, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (started && !reset && !restart) begin
      check("word_count", word_count, exp_pops);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=0x%0h expected=none", out_instr);
        end else begin
          check("out_instr", out_instr, sb_q[0].instr);
          check("out_addr", out_addr, sb_q[0].addr);
          if (out_ready) begin
            void'(sb_q.pop_front());
            exp_pops++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int got, cyc, acc0;
    int ops[5], rss[5], rts[5], rds[5], imms[5];

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_word_count", word_count, 0);
    check("rst_done", done, 0);
    check("rst_err", err_illegal, 0);
    @(posedge clk); #1; reset = 1'b0; started = 1'b1;

    // ADD with single-cycle latency
    send(0, 1, 2, 3, 0, 1'b1, 1'b0, 32'h00221820);
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'd0, acc);
    check("add_latency_valid", out_valid, 1);
    // LW then J
    send(5, 0, 8, 0, 4, 1'b1, 1'b0, 32'h8C080004);
    send(9, 0, 0, 0, 'h10, 1'b1, 1'b0, 32'h08000010);
    idle(1'b1, 3);
    do_restart();

    // Five back-to-back requests against a stalled output
    for (int i = 0; i < 5; i++) begin
      ops[i] = $urandom_range(0, 9); rss[i] = $urandom_range(0, 31);
      rts[i] = $urandom_range(0, 31); rds[i] = $urandom_range(0, 31);
      imms[i] = int'($urandom & 32'h03FF_FFFF);
    end
    got = 0; cyc = 0;
    while (got < 5 && cyc < 60) begin
      step(1'b1, ops[got], rss[got], rts[got], rds[got], imms[got], cyc >= 6, 1'b1, 32'd0, acc);
      if (acc) got++;
      if (cyc == 5) begin
        check("stall_accepts", got, 2);
        check("stall_in_ready", in_ready, 0);
      end
      cyc++;
    end
    check("five_accepted", got, 5);
    cyc = 0;
    while (exp_pops < 5 && cyc < 20) begin idle(1'b1, 1); cyc++; end
    check("five_word_count", word_count, 5);

    // Illegal op: accepted, flagged, nothing emitted
    send(12, 3, 4, 5, 0, 1'b1, 1'b1, 32'd0);
    idle(1'b1, 1);
    check("illegal_err", err_illegal, 1);
    check("illegal_no_valid", out_valid, 0);
    check("illegal_addr_hold", out_addr, 8'(int'(BASE) + 20));

    // Budget: sixth word fills it, further requests are refused
    send(8, 7, 9, 0, 'h8001, 1'b1, 1'b1, 32'd0);
    acc0 = n_acc;
    repeat (4) step(1'b1, 1, 2, 3, 4, 0, 1'b1, 1'b1, 32'd0, acc);
    check("budget_no_accept", n_acc, acc0);
    check("halt_done", done, 1);
    check("halt_in_ready", in_ready, 0);
    check("halt_out_valid", out_valid, 0);
    check("halt_word_count", word_count, MAXW);
    do_restart();
    check("restart_in_ready", in_ready, 1);
    send(3, 10, 11, 12, 0, 1'b1, 1'b1, 32'd0);
    idle(1'b1, 2);

    // Asynchronous reset with two words buffered
    send(2, 1, 1, 1, 0, 1'b0, 1'b1, 32'd0);
    send(6, 2, 2, 0, 'h1234, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #3;
    in_valid = 1'b0; reset = 1'b1;
    #1;
    check("areset_valid", out_valid, 0);
    check("areset_addr", out_addr, BASE);
    check("areset_word_count", word_count, 0);
    clear_model();
    @(posedge clk); #1; reset = 1'b0;

    // Randomized episodes, each run until the budget halts the block
    for (int e = 0; e < 6; e++) begin
      cyc = 0;
      while (exp_pops < MAXW && cyc < 300) begin
        int op;
        op = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        step($urandom_range(0, 3) != 0, op, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), int'($urandom & 32'h03FF_FFFF),
             $urandom_range(0, 2) != 0, 1'b1, 32'd0, acc);
        cyc++;
      end
      if (exp_pops < MAXW) check("episode_timeout", exp_pops, MAXW);
      idle(1'b1, 1);
      check("ep_done", done, 1);
      check("ep_err", err_illegal, exp_err);
      check("ep_sb_empty", sb_q.size(), 0);
      check("ep_word_count", word_count, MAXW);
      do_restart();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
